// File: rtl/multi_chan_measure_ctrl.sv
// Multi-channel measurement sequencer: stretches one start request across NCH
// counter clock domains, waits for every enabled counter to go idle (or for a
// timeout / abort), then presents the captured counts over valid/ready.
module multi_chan_measure_ctrl #(
    parameter int NCH         = 5,
    parameter int VAL_W       = 32,
    parameter int START_HOLD  = 4,
    parameter int SETTLE      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 10000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NCH-1:0]       ch_en,
    output logic [NCH-1:0]       ch_start,
    input  logic [NCH-1:0]       ch_busy,
    input  logic [NCH*VAL_W-1:0] ch_val,
    output logic                 busy,
    output logic [2:0]           state_o,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [NCH*VAL_W-1:0] res_val,
    output logic [NCH-1:0]       res_ok,
    output logic                 res_timeout,
    output logic                 res_aborted
);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int HMAX = (START_HOLD > SETTLE) ? START_HOLD : SETTLE;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]                     state_q, state_d;
    logic [NCH-1:0]                 en_q, en_d;
    logic [TW-1:0]                  tmo_q, tmo_d;
    logic [HW-1:0]                  hold_q, hold_d;
    logic                           quiet_q, quiet_d;
    logic [NCH-1:0]                 ch_start_q, ch_start_d;
    logic [NCH*VAL_W-1:0]           res_val_q, res_val_d;
    logic [NCH-1:0]                 res_ok_q, res_ok_d;
    logic                           res_to_q, res_to_d;
    logic                           res_ab_q, res_ab_d;
    logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
    logic [NCH-1:0]                 bsync;
    logic                           quiet;

    // Busy synchronisers: ch_busy is from foreign clock domains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], ch_busy};
    end

    assign bsync = sync_q[SYNC_STAGES-1];
    assign quiet = ((bsync & en_q) == '0);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            en_q       <= '0;
            tmo_q      <= '0;
            hold_q     <= '0;
            quiet_q    <= 1'b0;
            ch_start_q <= '0;
            res_val_q  <= '0;
            res_ok_q   <= '0;
            res_to_q   <= 1'b0;
            res_ab_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            tmo_q      <= tmo_d;
            hold_q     <= hold_d;
            quiet_q    <= quiet_d;
            ch_start_q <= ch_start_d;
            res_val_q  <= res_val_d;
            res_ok_q   <= res_ok_d;
            res_to_q   <= res_to_d;
            res_ab_q   <= res_ab_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        hold_d   = hold_q;
        quiet_d  = 1'b0;
        res_val_d = res_val_q;
        res_ok_d = res_ok_q;
        res_to_d = res_to_q;
        res_ab_d = res_ab_q;
        tmo_d    = tmo_q;
        // Saturating timeout counter, runs while a measurement is in flight
        if (state_q != S_IDLE && state_q != S_DONE && tmo_q != TW'(TIMEOUT))
            tmo_d = tmo_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    en_d      = ch_en;
                    tmo_d     = '0;
                    hold_d    = '0;
                    res_val_d = '0;
                    res_ok_d  = '0;
                    res_to_d  = 1'b0;
                    res_ab_d  = 1'b0;
                    state_d   = (ch_en != '0) ? S_ARM : S_DONE;
                end
            end
            S_ARM, S_SETTLE, S_WAIT: begin
                if (abort) begin
                    state_d   = S_DONE;
                    res_ab_d  = 1'b1;
                    res_ok_d  = '0;
                    res_val_d = '0;
                end else if (state_q == S_ARM) begin
                    hold_d = hold_q + 1'b1;
                    if (hold_q == HW'(START_HOLD - 1)) begin
                        hold_d  = '0;
                        state_d = S_SETTLE;
                    end
                end else if (state_q == S_SETTLE) begin
                    hold_d = hold_q + 1'b1;
                    if (hold_q == HW'(SETTLE - 1)) begin
                        hold_d  = '0;
                        state_d = S_WAIT;
                    end
                end else begin
                    // Completion needs two consecutive quiet samples; it beats timeout
                    quiet_d = quiet;
                    if (quiet && quiet_q) begin
                        state_d  = S_CAPTURE;
                        res_ok_d = en_q;
                    end else if (tmo_q == TW'(TIMEOUT)) begin
                        state_d  = S_CAPTURE;
                        res_to_d = 1'b1;
                        res_ok_d = en_q & ~bsync;
                    end
                end
            end
            S_CAPTURE: begin
                for (int i = 0; i < NCH; i++)
                    res_val_d[i*VAL_W +: VAL_W] = res_ok_q[i] ? ch_val[i*VAL_W +: VAL_W] : '0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Start level is registered so it leaves glitch-free toward slow domains
        ch_start_d = (state_d == S_ARM) ? en_d : '0;
    end

    // Outputs decoded from state and result registers
    always_comb begin
        busy        = (state_q != S_IDLE);
        res_valid   = (state_q == S_DONE);
        state_o     = state_q;
        ch_start    = ch_start_q;
        res_val     = res_val_q;
        res_ok      = res_ok_q;
        res_timeout = res_to_q;
        res_aborted = res_ab_q;
    end
endmodule
